// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing definitions: collector FSM states,
// the default hypervector width and the default LFSR seed.
package hdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } hvc_state_t;

  localparam int unsigned HV_DIM = 1024;
  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] SEED = 16'b1001010010110101;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1),
// one pseudo-random bit per cycle on out.
module lfsr
  import hdc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] INIT = SEED
) (
  input  logic clk,
  input  logic rst,
  output logic out
);

  logic [LFSR_W-1:0] state;
  logic              fb_c;

  assign fb_c = state[0] ^ state[2] ^ state[3] ^ state[5];
  assign out  = state[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= {fb_c, state[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_hv_collector.sv
// Collects the serial LFSR bitstream into D-bit hypervectors and hands them
// out through a one-entry valid/ready output register, NUM_HV per start.
module lfsr_hv_collector
  import hdc_pkg::*;
#(
  parameter int unsigned D      = HV_DIM,
  parameter int unsigned NUM_HV = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  output logic [D-1:0]              hv_out,
  output logic                      hv_valid,
  input  logic                      hv_ready,
  output logic [idx_w(NUM_HV)-1:0]  hv_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned FILL_W = $clog2(D + 1);
  localparam int unsigned GEN_W  = $clog2(NUM_HV + 1);
  localparam int unsigned IDX_W  = idx_w(NUM_HV);

  hvc_state_t        state, state_d;
  logic [D-1:0]      sr, sr_d;
  logic [FILL_W-1:0] fill_cnt, fill_d;
  logic [GEN_W-1:0]  gen_cnt, gen_d;
  logic [D-1:0]      hv_out_d;
  logic              hv_valid_d;
  logic [IDX_W-1:0]  hv_idx_d;
  logic              busy_d;
  logic              done_d;
  logic              xfer;

  // Next-state and next-register computation.
  always_comb begin
    state_d    = state;
    sr_d       = sr;
    fill_d     = fill_cnt;
    gen_d      = gen_cnt;
    hv_out_d   = hv_out;
    hv_valid_d = hv_valid;
    hv_idx_d   = hv_idx;
    done_d     = 1'b0;
    xfer       = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          fill_d  = '0;
          gen_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bit_valid) begin
          sr_d   = {sr[D-2:0], bit_in};
          fill_d = fill_cnt + FILL_W'(1);
          if (fill_cnt == FILL_W'(D - 1)) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Bits arriving here are dropped; the LFSR cannot be paused.
        if (!hv_valid || hv_ready) begin
          xfer       = 1'b1;
          hv_out_d   = sr;
          hv_valid_d = 1'b1;
          hv_idx_d   = IDX_W'(gen_cnt);
          gen_d      = gen_cnt + GEN_W'(1);
          fill_d     = '0;
          state_d    = (gen_cnt == GEN_W'(NUM_HV - 1)) ? DONE : FILL;
        end
      end
      DONE: begin
        if (!hv_valid) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A transfer in the same cycle as acceptance keeps hv_valid high.
    if (hv_valid && hv_ready && !xfer) begin
      hv_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      fill_cnt <= '0;
      gen_cnt  <= '0;
      hv_out   <= '0;
      hv_valid <= 1'b0;
      hv_idx   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      sr       <= sr_d;
      fill_cnt <= fill_d;
      gen_cnt  <= gen_d;
      hv_out   <= hv_out_d;
      hv_valid <= hv_valid_d;
      hv_idx   <= hv_idx_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_lfsr_hv_collector.sv
// Bench for lfsr_hv_collector: directed scenarios on a D=8 instance plus an
// LFSR-fed D=16 instance, all checked against a queue-based reference model.
module tb_lfsr_hv_collector;
  import hdc_pkg::*;

  localparam int P_IDLE    = 0;
  localparam int P_COLLECT = 1;
  localparam int P_FULL    = 2;
  localparam int P_FINISH  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start8 = 1'b0, bit8 = 1'b0, bv8 = 1'b0, rdy8 = 1'b0;
  logic [7:0]  hv_out8;
  logic        hv_valid8, busy8, done8;
  logic [0:0]  hv_idx8;

  logic        start16 = 1'b0, rdy16 = 1'b1;
  logic        lfsr_out;
  logic [15:0] hv_out16;
  logic        hv_valid16, busy16, done16;
  logic [1:0]  hv_idx16;

  lfsr u_lfsr (.clk(clk), .rst(rst), .out(lfsr_out));

  lfsr_hv_collector #(.D(8), .NUM_HV(2)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .bit_in(bit8), .bit_valid(bv8),
    .hv_out(hv_out8), .hv_valid(hv_valid8), .hv_ready(rdy8), .hv_idx(hv_idx8),
    .busy(busy8), .done(done8)
  );

  lfsr_hv_collector #(.D(16), .NUM_HV(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .bit_in(lfsr_out), .bit_valid(1'b1),
    .hv_out(hv_out16), .hv_valid(hv_valid16), .hv_ready(rdy16), .hv_idx(hv_idx16),
    .busy(busy16), .done(done16)
  );

  typedef struct {
    int          ph;
    logic [15:0] sr;
    int          fill;
    int          gen;
    logic [15:0] out;
    logic        valid;
    int          idx;
    logic        busy;
    logic        done;
  } mdl_t;

  mdl_t        m [2];
  logic        lb [$];
  int          lcnt = 0;
  logic [15:0] acc8 [$];
  logic [15:0] acc16 [$];
  logic        hist16 [$];
  logic        rec16 = 1'b0;
  int          done8_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] pat = 16'hB2F0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one collector, one rising edge.
  task automatic mstep(input int i, input int d, input int nhv, input logic r,
                       input logic st, input logic b, input logic bv, input logic rdy);
    mdl_t c, n;
    logic xfer;
    logic [15:0] mask;
    mask = 16'((32'd1 << d) - 1);
    c = m[i];
    n = c;
    xfer = 1'b0;
    if (r) begin
      n.ph = P_IDLE; n.sr = '0; n.fill = 0; n.gen = 0; n.out = '0;
      n.valid = 1'b0; n.idx = 0; n.busy = 1'b0; n.done = 1'b0;
    end else begin
      n.done = 1'b0;
      case (c.ph)
        P_IDLE: if (st) begin n.ph = P_COLLECT; n.fill = 0; n.gen = 0; end
        P_COLLECT: if (bv) begin
          n.sr = ((c.sr << 1) | 16'(b)) & mask;
          n.fill = c.fill + 1;
          if (n.fill == d) n.ph = P_FULL;
        end
        P_FULL: if (!c.valid || rdy) begin
          xfer = 1'b1;
          n.out = c.sr; n.valid = 1'b1; n.idx = c.gen; n.gen = c.gen + 1; n.fill = 0;
          n.ph = (n.gen == nhv) ? P_FINISH : P_COLLECT;
        end
        default: if (!c.valid) begin n.done = 1'b1; n.ph = P_IDLE; end
      endcase
      if (c.valid && rdy && !xfer) n.valid = 1'b0;
      n.busy = (n.ph != P_IDLE);
    end
    m[i] = n;
  endtask

  // One clock: log handshakes, advance models, then compare every output.
  task automatic tick();
    logic lb_now;
    logic [15:0] sd;
    int s;
    lb_now = (lb.size() > lcnt) ? lb[lcnt] : 1'b0;
    if (hv_valid8 && rdy8) acc8.push_back(16'(hv_out8));
    if (hv_valid16 && rdy16) acc16.push_back(hv_out16);
    if (rec16) hist16.push_back(lb_now);
    @(posedge clk);
    mstep(0, 8, 2, rst, start8, bit8, bv8, rdy8);
    mstep(1, 16, 4, rst, start16, lb_now, 1'b1, rdy16);
    // Output sequence obeys b[n] = b[n-16]^b[n-14]^b[n-13]^b[n-11].
    if (rst) begin
      sd = SEED;
      lb.delete();
      for (int k = 0; k < 16; k++) lb.push_back(sd[k]);
      lcnt = 0;
    end else begin
      lcnt++;
      while (lb.size() <= lcnt) begin
        s = lb.size();
        lb.push_back(lb[s-16] ^ lb[s-14] ^ lb[s-13] ^ lb[s-11]);
      end
    end
    #1;
    chk("valid8", 64'(hv_valid8), 64'(m[0].valid));
    chk("out8",   64'(hv_out8),   64'(m[0].out));
    chk("idx8",   64'(hv_idx8),   64'(m[0].idx));
    chk("busy8",  64'(busy8),     64'(m[0].busy));
    chk("done8",  64'(done8),     64'(m[0].done));
    chk("valid16", 64'(hv_valid16), 64'(m[1].valid));
    chk("out16",   64'(hv_out16),   64'(m[1].out));
    chk("idx16",   64'(hv_idx16),   64'(m[1].idx));
    chk("busy16",  64'(busy16),     64'(m[1].busy));
    chk("done16",  64'(done16),     64'(m[1].done));
    chk("lfsr",    64'(lfsr_out),   64'(lb[lcnt]));
    if (done8) done8_cnt++;
  endtask

  // One D=8 run fed with 8'hB2 then 8'hF0.
  task automatic run8(input int rdy_from, input bit gapped, input int extra_start, input int k_max);
    int j;
    bit skip;
    acc8.delete();
    done8_cnt = 0;
    start8 = 1'b1; bv8 = 1'(($urandom)); bit8 = 1'(($urandom)); rdy8 = (rdy_from == 0);
    tick();
    start8 = 1'b0;
    j = 0;
    for (int k = 1; k <= k_max; k++) begin
      start8 = (extra_start != 0) && (k == 3 || k == extra_start);
      bv8    = gapped ? ((k % 2) == 1) : 1'b1;
      rdy8   = (k >= rdy_from);
      skip   = !gapped && (k == 9);
      if (bv8 && !skip && j < 16) begin
        bit8 = pat[15-j];
        j++;
      end else begin
        bit8 = 1'(($urandom));
      end
      tick();
      if (rdy_from > 0 && k == 29) chk("bp_hold", 64'(hv_out8), 64'hB2);
      if (gapped && k == 15) chk("gap_t15", 64'(hv_valid8), 64'd0);
      if (gapped && k == 16) chk("gap_t16", 64'(hv_valid8), 64'd1);
    end
    chk("acc8_n", 64'(acc8.size()), 64'd2);
    if (acc8.size() == 2) begin
      chk("vec0", 64'(acc8[0]), 64'hB2);
      chk("vec1", 64'(acc8[1]), 64'hF0);
    end
    chk("done8_once", 64'(done8_cnt), 64'd1);
    chk("idle8", 64'(busy8), 64'd0);
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 2; i++) begin
      m[i].ph = P_IDLE; m[i].sr = '0; m[i].fill = 0; m[i].gen = 0; m[i].out = '0;
      m[i].valid = 1'b0; m[i].idx = 0; m[i].busy = 1'b0; m[i].done = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // LFSR-driven D=16 run: each vector is 16 consecutive LFSR bits.
    rdy16 = 1'b1; start16 = 1'b1;
    tick();
    start16 = 1'b0; rec16 = 1'b1;
    for (int k = 0; k < 80; k++) tick();
    rec16 = 1'b0;
    chk("acc16_n", 64'(acc16.size()), 64'd4);
    for (int k = 0; k < 4 && k < acc16.size(); k++) begin
      v = '0;
      for (int b = 0; b < 16; b++) v = {v[14:0], hist16[k*17+b]};
      chk("lfsr_vec", 64'(acc16[k]), 64'(v));
    end

    run8(0, 1'b0, 0, 40);    // basic
    run8(30, 1'b0, 0, 50);   // backpressure
    run8(0, 1'b1, 0, 50);    // gapped input

    // Reset four bits into vector 0, then a clean run.
    start8 = 1'b1; rdy8 = 1'b1; tick();
    start8 = 1'b0; bv8 = 1'b1;
    for (int k = 0; k < 4; k++) begin bit8 = ~pat[15-k]; tick(); end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_valid", 64'(hv_valid8), 64'd0);
    chk("rst_out", 64'(hv_out8), 64'd0);
    run8(0, 1'b0, 0, 40);

    run8(0, 1'b0, 19, 40);   // start ignored in FILL and DONE

    // Random traffic on both instances.
    for (int k = 0; k < 800; k++) begin
      rst     = ($urandom_range(0, 199) == 0);
      start8  = ($urandom_range(0, 15) == 0);
      bv8     = 1'(($urandom));
      bit8    = 1'(($urandom));
      rdy8    = ($urandom_range(0, 3) != 0);
      start16 = ($urandom_range(0, 15) == 0);
      rdy16   = 1'(($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
